decode_queue_stage: RTL and testbench

//  Parametrised successor to the single-slot decode stage. Accepts {op,a1,a2,b1,b2} from RX via valid/ready.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/decode_queue_stage_cmd_fifo.sv | 67 ++++++
 rtl/decode_queue_stage.sv | 105 ++++++++++
 tb/tb_decode_queue_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: the control struct carried with each queued
// command and the opcode decoder that produces it.
package alu_pkg;

  localparam int OP_W        = 8;
  localparam int OP_SWAP_BIT = 7;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    swap;
    logic    sub_en;
    logic    wb_en;
  } alu_ctrl_t;

  typedef struct packed {
    logic      legal;
    alu_ctrl_t ctrl;
  } alu_dec_t;

  // Bits [6:3] are reserved; any non-zero value there marks the opcode illegal.
  function automatic alu_dec_t decode_op(input logic [OP_W-1:0] op);
    alu_dec_t d;
    d.legal       = (op[6:3] == 4'b0000);
    d.ctrl.alu_op = alu_op_e'(op[2:0]);
    d.ctrl.swap   = op[OP_SWAP_BIT];
    d.ctrl.sub_en = (d.ctrl.alu_op == ALU_SUB) || (d.ctrl.alu_op == ALU_CMP);
    d.ctrl.wb_en  = (d.ctrl.alu_op != ALU_CMP);
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_stage_cmd_fifo.sv
// cmd_fifo: generic first-word-fall-through FIFO; the head entry is read straight
// from the storage registers so it is visible the cycle after it is written.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push, do_pop;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = level_reg;
  assign dout    = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= din;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage with a command queue: decodes and routes RX commands into a FIFO
// feeding the ALU. Optional statistics counters are enabled by DECODE_STATS_EN.
module decode_queue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid_in,
  output logic                   alu_ready_out,
  input  logic [7:0]             op,
  input  logic [DATA_W-1:0]      a1,
  input  logic [DATA_W-1:0]      a2,
  input  logic [DATA_W-1:0]      b1,
  input  logic [DATA_W-1:0]      b2,
  output logic                   cmd_valid_out,
  input  logic                   cmd_ready_in,
  output alu_ctrl_t              ctrl,
  output logic [DATA_W-1:0]      x0,
  output logic [DATA_W-1:0]      x1,
  output logic [DATA_W-1:0]      y0,
  output logic [DATA_W-1:0]      y1,
  output logic                   err_illegal,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            stat_ok_cnt,
  output logic [15:0]            stat_ill_cnt
);

  localparam int ENTRY_W = $bits(alu_ctrl_t) + 4 * DATA_W;

  alu_dec_t          dec;
  logic              accept, push, pop, full, empty;
  logic [DATA_W-1:0] rx0, rx1, ry0, ry1;
  logic [ENTRY_W-1:0] entry_in, entry_out;
  logic              err_illegal_reg;

  assign dec           = decode_op(op);
  assign alu_ready_out = ~full;
  assign accept        = rx_valid_in & alu_ready_out;
  assign push          = accept & dec.legal;
  assign cmd_valid_out = ~empty;
  assign pop           = cmd_valid_out & cmd_ready_in;

  always_comb begin
    rx0 = a1;
    rx1 = a2;
    ry0 = b1;
    ry1 = b2;
    if (op[OP_SWAP_BIT]) begin
      rx0 = b1;
      rx1 = b2;
      ry0 = a1;
      ry1 = a2;
    end
  end

  assign entry_in = {dec.ctrl, rx0, rx1, ry0, ry1};
  assign {ctrl, x0, x1, y0, y1} = entry_out;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry_in),
    .pop   (pop),
    .dout  (entry_out),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Illegal commands are swallowed here; only a one-cycle flag remains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_illegal_reg <= 1'b0;
    else     err_illegal_reg <= accept & ~dec.legal;
  end
  assign err_illegal = err_illegal_reg;

`ifdef DECODE_STATS_EN
  logic [15:0] stat_ok_cnt_reg, stat_ill_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok_cnt_reg  <= '0;
      stat_ill_cnt_reg <= '0;
    end else begin
      if (push && stat_ok_cnt_reg != 16'hFFFF)
        stat_ok_cnt_reg <= stat_ok_cnt_reg + 16'd1;
      if (accept && !dec.legal && stat_ill_cnt_reg != 16'hFFFF)
        stat_ill_cnt_reg <= stat_ill_cnt_reg + 16'd1;
    end
  end
  assign stat_ok_cnt  = stat_ok_cnt_reg;
  assign stat_ill_cnt = stat_ill_cnt_reg;
`else
  assign stat_ok_cnt  = 16'h0000;
  assign stat_ill_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage (DATA_W=8, DEPTH=4); honours DECODE_STATS_EN.
module tb_decode_queue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    alu_ctrl_t  ctrl;
    logic [7:0] x0, x1, y0, y1;
  } exp_t;

  logic clk, rst, rx_valid_in, alu_ready_out, cmd_valid_out, cmd_ready_in, err_illegal;
  logic [7:0] op, a1, a2, b1, b2, x0, x1, y0, y1;
  alu_ctrl_t ctrl;
  logic [LVL_W-1:0] level;
  logic [15:0] stat_ok_cnt, stat_ill_cnt;

  exp_t sb[$];
  int model_level;
  bit exp_err;
  logic [15:0] ok_cnt, ill_cnt;
  int checks, errors;
  bit acc;

  decode_queue_stage #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_valid_in(rx_valid_in), .alu_ready_out(alu_ready_out),
    .op(op), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .cmd_valid_out(cmd_valid_out), .cmd_ready_in(cmd_ready_in), .ctrl(ctrl),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .err_illegal(err_illegal), .level(level),
    .stat_ok_cnt(stat_ok_cnt), .stat_ill_cnt(stat_ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t predict(input logic [7:0] o, p1, p2, q1, q2);
    exp_t e;
    e.ctrl.alu_op = alu_op_e'(o[2:0]);
    e.ctrl.swap   = o[7];
    case (o[2:0])
      3'd1:    {e.ctrl.sub_en, e.ctrl.wb_en} = 2'b11;
      3'd7:    {e.ctrl.sub_en, e.ctrl.wb_en} = 2'b10;
      default: {e.ctrl.sub_en, e.ctrl.wb_en} = 2'b01;
    endcase
    if (o[7]) {e.x0, e.x1, e.y0, e.y1} = {q1, q2, p1, p2};
    else      {e.x0, e.x1, e.y0, e.y1} = {p1, p2, q1, q2};
    return e;
  endfunction

  // Drives one clock cycle and advances the reference model; no checking here.
  task automatic cycle(input bit v, input logic [7:0] o, p1, p2, q1, q2,
                       input bit rdy, output bit accepted);
    bit lg, popx;
    exp_t e;
    rx_valid_in = v; op = o; a1 = p1; a2 = p2; b1 = q1; b2 = q2; cmd_ready_in = rdy;
    accepted = v && (model_level < DEPTH);
    lg   = (o[6:3] == 4'b0000);
    popx = (model_level > 0) && rdy;
    @(posedge clk); #1;
    if (popx) begin
      e = sb.pop_front();
      $display("txn pop  op=%0d x0=%h x1=%h y0=%h y1=%h", e.ctrl.alu_op, e.x0, e.x1, e.y0, e.y1);
    end
    if (accepted && lg) sb.push_back(predict(o, p1, p2, q1, q2));
    model_level = model_level + ((accepted && lg) ? 1 : 0) - (popx ? 1 : 0);
    exp_err = accepted && !lg;
    if (accepted && lg && ok_cnt != 16'hFFFF) ok_cnt++;
    if (accepted && !lg && ill_cnt != 16'hFFFF) ill_cnt++;
    rx_valid_in = 1'b0;
    cmd_ready_in = 1'b0;
  endtask

  task automatic clear_model();
    sb.delete();
    model_level = 0; exp_err = 0; ok_cnt = '0; ill_cnt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid_in = 0; cmd_ready_in = 0; op = 0; a1 = 0; a2 = 0; b1 = 0; b2 = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cmd_valid_out); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {ctrl, x0, x1, y0, y1}); end
    checks++; if (alu_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", alu_ready_out); end
    checks++; if ({stat_ok_cnt, stat_ill_cnt} !== '0) begin errors++; $display("FAIL reset_stats got=%h exp=0", {stat_ok_cnt, stat_ill_cnt}); end
    rst = 1'b0;
  endtask

  task automatic test_route();
    cycle(1, 8'h01, 8'd1, 8'd2, 8'd3, 8'd4, 1, acc);
    checks++; if (cmd_valid_out !== 1'b1) begin errors++; $display("FAIL route_valid got=%b exp=1", cmd_valid_out); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL route_plain got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
    checks++; if (ctrl.alu_op !== ALU_SUB) begin errors++; $display("FAIL route_op1 got=%0d exp=1", ctrl.alu_op); end
    cycle(1, 8'h82, 8'd1, 8'd2, 8'd3, 8'd4, 1, acc);
    checks++; if (level !== LVL_W'(model_level)) begin errors++; $display("FAIL swap_level got=%0d exp=%0d", level, model_level); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL route_swap got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
    checks++; if ({x0, x1, y0, y1} !== 32'h03040102) begin errors++; $display("FAIL swap_operands got=%h exp=03040102", {x0, x1, y0, y1}); end
    cycle(0, 8'h00, 0, 0, 0, 0, 1, acc);
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL route_drain got=%b exp=0", cmd_valid_out); end
  endtask

  task automatic test_full();
    bit pending;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'(i) | (i[0] ? 8'h80 : 8'h00), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, acc);
      checks++; if (level !== LVL_W'(model_level)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, model_level); end
    end
    checks++; if (alu_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", alu_ready_out); end
    cycle(1, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 0, acc);
    pending = !acc;
    checks++; if (level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL full_hold got=%0d exp=%0d", level, DEPTH); end
    for (int n = 0; n < 20 && (sb.size() > 0 || pending); n++) begin
      if (model_level > 0) begin
        checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL drain_order got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
      end
      cycle(pending, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 1, acc);
      if (acc) pending = 0;
    end
    checks++; if (level !== '0 || sb.size() != 0) begin errors++; $display("FAIL drain_done got=%0d exp=0", level); end
  endtask

  task automatic test_illegal();
    cycle(1, 8'h03, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 0, acc);
    cycle(1, 8'h18, 8'h01, 8'h01, 8'h01, 8'h01, 0, acc);
    checks++; if (err_illegal !== exp_err) begin errors++; $display("FAIL illegal_pulse got=%b exp=%b", err_illegal, exp_err); end
    checks++; if (level !== LVL_W'(model_level)) begin errors++; $display("FAIL illegal_level got=%0d exp=%0d", level, model_level); end
    checks++; if (cmd_valid_out !== 1'b1) begin errors++; $display("FAIL illegal_valid got=%b exp=1", cmd_valid_out); end
`ifdef DECODE_STATS_EN
    checks++; if (stat_ill_cnt !== ill_cnt) begin errors++; $display("FAIL illegal_stat got=%0d exp=%0d", stat_ill_cnt, ill_cnt); end
`else
    checks++; if (stat_ill_cnt !== 16'h0) begin errors++; $display("FAIL illegal_stat got=%0d exp=0", stat_ill_cnt); end
`endif
    cycle(0, 8'h00, 0, 0, 0, 0, 0, acc);
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_once got=%b exp=0", err_illegal); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL illegal_head got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
    cycle(0, 8'h00, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic test_push_pop();
    cycle(1, 8'h06, 8'h10, 8'h20, 8'h30, 8'h40, 0, acc);
    cycle(1, 8'h87, 8'h50, 8'h60, 8'h70, 8'h80, 1, acc);
    checks++; if (level !== 1 || model_level != 1) begin errors++; $display("FAIL pushpop_level got=%0d exp=1", level); end
    checks++; if (cmd_valid_out !== 1'b1) begin errors++; $display("FAIL pushpop_valid got=%b exp=1", cmd_valid_out); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL pushpop_head got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
    cycle(0, 8'h00, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, 8'h02, 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 0, acc);
    checks++; if (level !== 3) begin errors++; $display("FAIL mid_prefill got=%0d exp=3", level); end
    #2 rst = 1'b1;
    #1;
    clear_model();
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", cmd_valid_out); end
    checks++; if (level !== '0) begin errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 8'h04, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, acc);
    checks++; if (cmd_valid_out !== 1'b1 || level !== 1) begin errors++; $display("FAIL mid_latency got=%b/%0d exp=1/1", cmd_valid_out, level); end
    checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL mid_head got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
    cycle(0, 8'h00, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] o;
    for (int n = 0; n < 200; n++) begin
      if (model_level > 0) begin
        checks++; if ({ctrl, x0, x1, y0, y1} !== sb[0]) begin errors++; $display("FAIL b2b_head got=%h exp=%h", {ctrl, x0, x1, y0, y1}, sb[0]); end
      end
      o = {1'($urandom), ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 3'($urandom)};
      cycle(n < 180 && $urandom_range(0, 3) != 0, o, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            (n >= 180) || $urandom_range(0, 1) == 1, acc);
      checks++; if (level !== LVL_W'(model_level) || cmd_valid_out !== (model_level > 0)) begin
        errors++; $display("FAIL b2b_level got=%0d exp=%0d", level, model_level); end
      checks++; if (err_illegal !== exp_err) begin errors++; $display("FAIL b2b_err got=%b exp=%b", err_illegal, exp_err); end
    end
    checks++; if (model_level != 0 || level !== '0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", level); end
`ifdef DECODE_STATS_EN
    checks++; if ({stat_ok_cnt, stat_ill_cnt} !== {ok_cnt, ill_cnt}) begin errors++; $display("FAIL b2b_stats got=%h exp=%h", {stat_ok_cnt, stat_ill_cnt}, {ok_cnt, ill_cnt}); end
`else
    checks++; if ({stat_ok_cnt, stat_ill_cnt} !== '0) begin errors++; $display("FAIL b2b_stats got=%h exp=0", {stat_ok_cnt, stat_ill_cnt}); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_route();
    test_full();
    test_illegal();
    test_push_pop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
